// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Build with STREAM_DEMUX_1_4_CNT_EN defined to add per-output delivery counters.
package stream_demux_pkg;

  localparam int N_OUT = 4;
  localparam int CNT_W = 8;

  typedef logic [1:0] sel_t;

`ifdef STREAM_DEMUX_1_4_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // One-hot destination mask for a select code.
  function automatic logic [N_OUT-1:0] sel_decode(input sel_t sel);
    logic [N_OUT-1:0] mask;
    mask = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry register slot for one demux output stream.
// With STREAM_DEMUX_1_4_CNT_EN defined it also counts delivered beats (wrapping).
module stream_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
`ifdef STREAM_DEMUX_1_4_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = r_valid & i_ready;

  // A load always wins over a drain, so a same-cycle refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

`ifdef STREAM_DEMUX_1_4_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer with one slot per output.
// STREAM_DEMUX_1_4_CNT_EN adds out_cnt0..3 delivered-beat counters.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  sel_t             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
`ifdef STREAM_DEMUX_1_4_CNT_EN
  ,
  output logic [CNT_W-1:0] out_cnt0,
  output logic [CNT_W-1:0] out_cnt1,
  output logic [CNT_W-1:0] out_cnt2,
  output logic [CNT_W-1:0] out_cnt3
`endif
);

  logic [N_OUT-1:0] w_valid;
  logic [N_OUT-1:0] w_load;
  logic [WIDTH-1:0] w_data [N_OUT];
`ifdef STREAM_DEMUX_1_4_CNT_EN
  logic [CNT_W-1:0] w_cnt  [N_OUT];
`endif

  // Only the addressed slot gates acceptance; other stalled consumers do not.
  assign in_ready = ~w_valid[in_sel] | out_ready[in_sel];
  assign w_load   = (in_valid & in_ready) ? sel_decode(in_sel) : '0;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[g]),
      .i_data (in_data),
      .i_ready(out_ready[g]),
      .o_valid(w_valid[g]),
      .o_data (w_data[g])
`ifdef STREAM_DEMUX_1_4_CNT_EN
      ,
      .o_cnt  (w_cnt[g])
`endif
    );
  end

  assign out_valid = w_valid;
  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];
  assign out_data3 = w_data[3];

`ifdef STREAM_DEMUX_1_4_CNT_EN
  assign out_cnt0 = w_cnt[0];
  assign out_cnt1 = w_cnt[1];
  assign out_cnt2 = w_cnt[2];
  assign out_cnt3 = w_cnt[3];
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4.
// Counter checks are compiled in when STREAM_DEMUX_1_4_CNT_EN is defined.
module tb_stream_demux_1_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [3:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
`ifdef STREAM_DEMUX_1_4_CNT_EN
  logic [7:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3;
`endif

  int nCompared;
  int nMismatched;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3)
`ifdef STREAM_DEMUX_1_4_CNT_EN
    ,
    .out_cnt0 (out_cnt0),
    .out_cnt1 (out_cnt1),
    .out_cnt2 (out_cnt2),
    .out_cnt3 (out_cnt3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Drive inputs 1ns after a rising edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [3:0] d,
                               input logic [3:0] rdy);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", {28'd0, out_valid}, 32'h0);
    checkOutput("rst_d0", {28'd0, out_data0}, 32'h0);
    checkOutput("rst_d1", {28'd0, out_data1}, 32'h0);
    checkOutput("rst_d2", {28'd0, out_data2}, 32'h0);
    checkOutput("rst_d3", {28'd0, out_data3}, 32'h0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'h1);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_valid", {28'd0, out_valid}, 32'h0);

    // Directed routing, consumers stalled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i[1:0], 4'ha + i[3:0], 4'b0000);
      checkOutput($sformatf("route_ready%0d", i), {31'd0, in_ready}, 32'h1);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    checkOutput("route_valid", {28'd0, out_valid}, 32'hf);
    checkOutput("route_d0", {28'd0, out_data0}, 32'ha);
    checkOutput("route_d1", {28'd0, out_data1}, 32'hb);
    checkOutput("route_d2", {28'd0, out_data2}, 32'hc);
    checkOutput("route_d3", {28'd0, out_data3}, 32'hd);

    // Per-slot backpressure on slot 2
    applyStimulus(1'b1, 2'd2, 4'h5, 4'b0000);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'h0);
    tick();
    checkOutput("bp_d2_held", {28'd0, out_data2}, 32'hc);
    checkOutput("bp_valid", {28'd0, out_valid}, 32'hf);
    applyStimulus(1'b1, 2'd1, 4'h6, 4'b0010);
    checkOutput("bp_sel1_ready", {31'd0, in_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    checkOutput("bp_d1", {28'd0, out_data1}, 32'h6);
    checkOutput("bp_d2_still", {28'd0, out_data2}, 32'hc);
    checkOutput("bp_valid2", {28'd0, out_valid}, 32'hf);

    // Drain slot 0, reload with 3, then simultaneous load/drain with 7
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0001);
    tick();
    checkOutput("drain_valid", {28'd0, out_valid}, 32'he);
    checkOutput("drain_d0_kept", {28'd0, out_data0}, 32'ha);
    applyStimulus(1'b1, 2'd0, 4'h3, 4'b0000);
    tick();
    checkOutput("load3_d0", {28'd0, out_data0}, 32'h3);
    applyStimulus(1'b1, 2'd0, 4'h7, 4'b0001);
    checkOutput("ld_dr_ready", {31'd0, in_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
    checkOutput("ld_dr_valid", {28'd0, out_valid}, 32'hf);
    checkOutput("ld_dr_d0", {28'd0, out_data0}, 32'h7);
`ifdef STREAM_DEMUX_1_4_CNT_EN
    checkOutput("cnt0", {24'd0, out_cnt0}, 32'h2);
    checkOutput("cnt1", {24'd0, out_cnt1}, 32'h1);
    checkOutput("cnt2", {24'd0, out_cnt2}, 32'h0);
`endif

    // Async reset between edges with all slots full
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {28'd0, out_valid}, 32'h0);
    checkOutput("async_d0", {28'd0, out_data0}, 32'h0);
    checkOutput("async_d1", {28'd0, out_data1}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("async_after", {28'd0, out_valid}, 32'h0);

    // Full throughput on slot 3 with consumer always ready
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd3, 4'h8 + i[3:0], 4'b1000);
      checkOutput($sformatf("tp_ready%0d", i), {31'd0, in_ready}, 32'h1);
      tick();
      checkOutput($sformatf("tp_d3_%0d", i), {28'd0, out_data3}, 32'h8 + i);
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b1000);
    tick();
    checkOutput("tp_drained", {28'd0, out_valid}, 32'h0);

`ifdef STREAM_DEMUX_1_4_CNT_EN
    checkOutput("tp_cnt3", {24'd0, out_cnt3}, 32'h3);
    // Counter wrap: 253 more deliveries make 256 in total
    for (int i = 0; i < 253; i++) begin
      applyStimulus(1'b1, 2'd3, i[3:0], 4'b1000);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b1000);
    tick();
    checkOutput("wrap_cnt3", {24'd0, out_cnt3}, 32'h0);
    applyStimulus(1'b1, 2'd3, 4'h1, 4'b1000);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 4'b1000);
    tick();
    checkOutput("wrap_cnt3_one", {24'd0, out_cnt3}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
